// File: rtl/i2c_pkg.sv
// Shared I2C constants: FSM state encodings, R/W polarity and the default
// target address. Used by both the slave and the companion master.
package i2c_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_ACK_A = 3'd2;
  localparam logic [2:0] ST_RX    = 3'd3;
  localparam logic [2:0] ST_ACK_D = 3'd4;
  localparam logic [2:0] ST_TX    = 3'd5;
  localparam logic [2:0] ST_MACK  = 3'd6;
  localparam logic [2:0] ST_WAIT  = 3'd7;

  // R/W bit value meaning "master writes to the target".
  localparam logic RW_MASTER_WRITE = 1'b1;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

endpackage

// File: rtl/i2c_slave_if.sv
// User-side handshake of the I2C slave: byte source for reads, byte sink
// for writes, and transfer status flags.
interface i2c_slave_if;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_hit;
  logic       busy;

  modport slave (
    input  tx_data,
    output tx_req, rx_data, rx_valid, addr_hit, busy
  );

  modport master (
    output tx_data,
    input  tx_req, rx_data, rx_valid, addr_hit, busy
  );
endinterface

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus detection of SCL edges and of
// START/STOP conditions on the synchronized lines.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl_s;

  assign scl_s = scl_sync[1];
  assign sda   = sda_sync[1];

  // Synchronize both lines and keep one cycle of history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_prev <= scl_s;
      sda_prev <= sda;
    end
  end

  // SDA moving while SCL stays high is START (falling) or STOP (rising).
  always_comb begin
    scl_rise  = scl_s & ~scl_prev;
    scl_fall  = ~scl_s & scl_prev;
    start_det = scl_s & scl_prev & sda_prev & ~sda;
    stop_det  = scl_s & scl_prev & ~sda_prev & sda;
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address decode, byte receive with ACK, byte transmit with
// master ACK/NACK handling, open-drain SDA driver.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         scl,
  inout  wire         sdl,
  i2c_slave_if.slave  bus
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic [6:0] tx_shift;
  logic       rw;
  logic       sda_low;
  logic [7:0] next_byte;

  // SCL is observe-only; SDA is pulled low or released, never driven high.
  assign scl = 1'bz;
  assign sdl = sda_low ? 1'b0 : 1'bz;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl),
    .sda_in    (sdl),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Byte as it will look after shifting in the current SDA level.
  always_comb begin
    next_byte = {shreg, sda_s};
  end

  // Protocol FSM. In the ACK states sda_low doubles as the phase flag:
  // the first SCL fall starts the ACK, the second one ends it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      tx_shift     <= '0;
      rw           <= 1'b0;
      sda_low      <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.tx_req   <= 1'b0;
      bus.addr_hit <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.tx_req   <= 1'b0;
      if (start_det) begin
        state        <= ST_ADDR;
        bit_cnt      <= 3'd7;
        shreg        <= '0;
        sda_low      <= 1'b0;
        bus.addr_hit <= 1'b0;
        bus.busy     <= 1'b1;
      end else if (stop_det) begin
        state        <= ST_IDLE;
        sda_low      <= 1'b0;
        bus.addr_hit <= 1'b0;
        bus.busy     <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: if (scl_rise) begin
            shreg <= next_byte[6:0];
            if (bit_cnt == 3'd0) begin
              if (next_byte[7:1] == SLAVE_ADDR) begin
                rw    <= next_byte[0];
                state <= ST_ACK_A;
              end else begin
                state <= ST_WAIT;
              end
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          ST_ACK_A: if (scl_fall) begin
            if (!sda_low) begin
              sda_low      <= 1'b1;
              bus.addr_hit <= 1'b1;
            end else if (rw == RW_MASTER_WRITE) begin
              sda_low <= 1'b0;
              bit_cnt <= 3'd7;
              state   <= ST_RX;
            end else begin
              tx_shift   <= bus.tx_data[6:0];
              sda_low    <= ~bus.tx_data[7];
              bus.tx_req <= 1'b1;
              bit_cnt    <= 3'd7;
              state      <= ST_TX;
            end
          end
          ST_RX: if (scl_rise) begin
            shreg <= next_byte[6:0];
            if (bit_cnt == 3'd0) begin
              bus.rx_data  <= next_byte;
              bus.rx_valid <= 1'b1;
              state        <= ST_ACK_D;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
          ST_ACK_D: if (scl_fall) begin
            if (!sda_low) begin
              sda_low <= 1'b1;
            end else begin
              sda_low <= 1'b0;
              bit_cnt <= 3'd7;
              state   <= ST_RX;
            end
          end
          ST_TX: if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_low <= 1'b0;
              state   <= ST_MACK;
            end else begin
              sda_low  <= ~tx_shift[6];
              tx_shift <= {tx_shift[5:0], 1'b0};
              bit_cnt  <= bit_cnt - 1'b1;
            end
          end
          // A fall can only reach here after an ACKed rise; NACK leaves on the rise.
          ST_MACK: begin
            if (scl_rise && sda_s) begin
              state <= ST_WAIT;
            end else if (scl_fall) begin
              tx_shift   <= bus.tx_data[6:0];
              sda_low    <= ~bus.tx_data[7];
              bus.tx_req <= 1'b1;
              bit_cnt    <= 3'd7;
              state      <= ST_TX;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: directed scenarios followed by random
// transactions checked against a transaction-level expectation model.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  wire  scl_bus;
  wire  sdl_bus;

  pullup (scl_bus);
  pullup (sdl_bus);
  assign scl_bus = m_scl ? 1'bz : 1'b0;
  assign sdl_bus = m_sda ? 1'bz : 1'b0;

  i2c_slave_if bus ();

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk (clk),
    .rst (rst),
    .scl (scl_bus),
    .sdl (sdl_bus),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_cnt  = 0;
  int tx_cnt  = 0;
  logic [7:0] rx_q[$];

  // Pulse monitor, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rx_cnt++;
      rx_q.push_back(bus.rx_data);
    end
    if (bus.tx_req === 1'b1) tx_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_bit(input logic b, output logic s);
    m_sda = b;
    #Q m_scl = 1'b1;
    #Q s = sdl_bus;
    #Q m_scl = 1'b0;
    #Q;
  endtask

  task automatic do_start();
    m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b0;
    #Q m_scl = 1'b0;
    #Q;
  endtask

  task automatic do_stop();
    m_sda = 1'b0;
    #Q m_scl = 1'b1;
    #Q m_sda = 1'b1;
    #(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
  endtask

  // Asserts rst in the middle of an SCL-high phase with the master releasing SDA.
  task automatic rst_in_high(output logic pre);
    m_sda = 1'b1;
    #Q m_scl = 1'b1;
    #20 pre = sdl_bus;
    rst = 1'b1;
    #1;
    chk("rst_sdl_released", sdl_bus, 1);
    chk("rst_rx_data", bus.rx_data, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_tx_req", bus.tx_req, 0);
    chk("rst_addr_hit", bus.addr_hit, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_state", dut.state, ST_IDLE);
    #(29 + Q) m_scl = 1'b0;
    #Q rst = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic       pre;
    logic [7:0] r;
    logic [6:0] addr;
    logic       rw;
    logic       hit;
    int         n;
    int         rx0;
    int         tx0;
    logic [7:0] data [3];

    bus.tx_data = 8'h00;
    #(4*Q);
    chk("reset_rx_data", bus.rx_data, 0);
    chk("reset_rx_valid", bus.rx_valid, 0);
    chk("reset_tx_req", bus.tx_req, 0);
    chk("reset_addr_hit", bus.addr_hit, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_sdl", sdl_bus, 1);
    rst = 1'b0;
    #(2*Q);

    // Write of one byte.
    rx0 = rx_cnt;
    do_start();
    chk("wr_busy", bus.busy, 1);
    send_byte(8'hA1, ack);
    chk("wr_addr_ack", ack, 0);
    chk("wr_addr_hit", bus.addr_hit, 1);
    send_byte(8'hA5, ack);
    chk("wr_data_ack", ack, 0);
    chk("wr_rx_pulses", rx_cnt - rx0, 1);
    chk("wr_rx_data", bus.rx_data, 8'hA5);
    do_stop();
    chk("wr_stop_busy", bus.busy, 0);
    chk("wr_stop_hit", bus.addr_hit, 0);

    // Address mismatch.
    rx0 = rx_cnt;
    do_start();
    send_byte(8'hA3, ack);
    chk("nomatch_nack", ack, 1);
    send_byte(8'h5A, ack);
    chk("nomatch_data_nack", ack, 1);
    chk("nomatch_no_rx", rx_cnt - rx0, 0);
    chk("nomatch_hit", bus.addr_hit, 0);
    do_stop();

    // Single-byte read ended by master NACK.
    tx0 = tx_cnt;
    bus.tx_data = 8'h3C;
    do_start();
    send_byte(8'hA0, ack);
    chk("rd_addr_ack", ack, 0);
    read_byte(r);
    chk("rd_byte", r, 8'h3C);
    clk_bit(1'b1, s);
    chk("rd_nack_wait", dut.state, ST_WAIT);
    chk("rd_tx_req", tx_cnt - tx0, 1);
    do_stop();
    chk("rd_stop_idle", dut.state, ST_IDLE);
    chk("rd_stop_busy", bus.busy, 0);

    // Two-byte read.
    tx0 = tx_cnt;
    bus.tx_data = 8'h12;
    do_start();
    send_byte(8'hA0, ack);
    read_byte(r);
    chk("mrd_byte0", r, 8'h12);
    bus.tx_data = 8'h34;
    clk_bit(1'b0, s);
    read_byte(r);
    chk("mrd_byte1", r, 8'h34);
    clk_bit(1'b1, s);
    chk("mrd_tx_req", tx_cnt - tx0, 2);
    do_stop();

    // Write, then repeated START into a read.
    do_start();
    send_byte(8'hA1, ack);
    send_byte(8'h77, ack);
    chk("rs_data_ack", ack, 0);
    do_start();
    chk("rs_state_addr", dut.state, ST_ADDR);
    chk("rs_hit_cleared", bus.addr_hit, 0);
    bus.tx_data = 8'hC3;
    send_byte(8'hA0, ack);
    chk("rs_addr_ack", ack, 0);
    chk("rs_state_tx", dut.state, ST_TX);
    read_byte(r);
    chk("rs_byte", r, 8'hC3);
    clk_bit(1'b1, s);
    do_stop();

    // Reset during bit 4 of a received byte; remainder must be ignored.
    rx0 = rx_cnt;
    do_start();
    send_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) clk_bit(1'b1, s);
    rst_in_high(pre);
    for (int i = 0; i < 4; i++) clk_bit(1'b0, s);
    clk_bit(1'b1, ack);
    chk("postrst_no_ack", ack, 1);
    chk("postrst_no_rx", rx_cnt - rx0, 0);
    do_stop();

    // Reset while the address ACK is being driven.
    do_start();
    for (int i = 7; i >= 0; i--) begin
      r = 8'hA1;
      clk_bit(r[i], s);
    end
    rst_in_high(pre);
    chk("ack_driven_pre_rst", pre, 0);
    do_stop();

    // Random transactions.
    for (int t = 0; t < 8; t++) begin
      addr = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
      rw   = 1'($urandom_range(0, 1));
      n    = $urandom_range(1, 3);
      hit  = (addr == 7'h50);
      for (int k = 0; k < 3; k++) data[k] = 8'($urandom);
      rx0 = rx_cnt;
      tx0 = tx_cnt;
      rx_q.delete();
      if (rw) begin
        do_start();
        send_byte({addr, 1'b1}, ack);
        chk("rnd_wr_addr_ack", ack, !hit);
        if (hit) begin
          for (int k = 0; k < n; k++) begin
            send_byte(data[k], ack);
            chk("rnd_wr_data_ack", ack, 0);
          end
          chk("rnd_wr_rx_count", rx_cnt - rx0, n);
          for (int k = 0; k < n; k++) chk("rnd_wr_rx_byte", rx_q[k], data[k]);
        end else begin
          chk("rnd_wr_no_rx", rx_cnt - rx0, 0);
        end
      end else begin
        bus.tx_data = data[0];
        do_start();
        send_byte({addr, 1'b0}, ack);
        chk("rnd_rd_addr_ack", ack, !hit);
        if (hit) begin
          for (int k = 0; k < n; k++) begin
            read_byte(r);
            chk("rnd_rd_byte", r, data[k]);
            if (k < n - 1) begin
              bus.tx_data = data[k+1];
              clk_bit(1'b0, s);
            end else begin
              clk_bit(1'b1, s);
            end
          end
        end
        chk("rnd_rd_tx_count", tx_cnt - tx0, hit ? n : 0);
      end
      chk("rnd_addr_hit", bus.addr_hit, hit);
      do_stop();
      chk("rnd_stop_busy", bus.busy, 0);
      chk("rnd_stop_hit", bus.addr_hit, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to.
REQ-002 clk  input  1  system clock; oversamples the bus, at least 8x the SCL rate.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 scl  inout(wand)  1  bus clock; only sampled, never driven (driven as 1'bZ).
REQ-005 sdl  inout(wand)  1  bus data, open-drain: driven 0 or 1'bZ only.
REQ-006 tx_data  input  8  byte returned to the master on read transfers.
REQ-007 tx_req  output  1  one-clk pulse: tx_data is latched this cycle; present the next byte before the next pulse.
REQ-008 rx_data  output  8  last byte received from the master.
REQ-009 rx_valid  output  1  one-clk pulse: rx_data updated.
REQ-010 addr_hit  output  1  high from the address ACK until the next STOP or START.
REQ-011 busy  output  1  high from START detection until STOP detection.

Function
REQ-012 scl and sdl each pass through a 2-flop synchronizer; all edges and levels below refer to the synchronized signals.
REQ-013 START: sdl falls while scl is high; STOP: sdl rises while scl is high.
REQ-014 States: IDLE, ADDR, ACK_A, RX, ACK_D, TX, MACK, WAIT.
REQ-015 START from any state goes to ADDR: bit counter = 7, shift register cleared, sdl released, addr_hit = 0.
REQ-016 STOP from any state goes to IDLE: sdl released, busy = 0, addr_hit = 0.
REQ-017 START and STOP win over any concurrent scl edge.
REQ-018 Bits are shifted in MSB first on scl rising edges. Byte 1 = address[6:0] followed by the R/W bit.
REQ-019 ADDR, after 8 bits, on address match: go to ACK_A and drive sdl = 0 from the next scl falling edge until the following scl falling edge.
REQ-020 ADDR, on address mismatch: go to WAIT with sdl released (NACK); WAIT ignores the bus until START or STOP.
REQ-021 R/W convention: R/W = 1 means the master writes (go to RX after ACK_A); R/W = 0 means the master reads (go to TX after ACK_A).
REQ-022 RX: after 8 rising edges, rx_data = shifted byte and rx_valid pulses on the same clk.
REQ-023 RX then goes to ACK_D, which ACKs exactly as in REQ-019, then returns to RX for the next byte.
REQ-024 TX entry: at the ACK_A-ending scl falling edge, tx_data is latched and tx_req pulses.
REQ-025 TX: MSB is driven (0 → drive low, 1 → release); each subsequent scl falling edge presents the next bit.
REQ-026 TX, after the 8th bit's falling edge: sdl is released and the state goes to MACK.
REQ-027 MACK: sample sdl on the scl rising edge.
REQ-028 MACK with sdl = 0 (ACK): at the next falling edge, latch the next byte, pulse tx_req, go to TX.
REQ-029 MACK with sdl = 1 (NACK): go to WAIT.
REQ-030 sdl is never changed while synchronized scl is high, except the release forced by STOP/START handling.
REQ-031 Repeated START with no STOP is legal and restarts address decoding.

Reset
REQ-032 On rst: state = IDLE, synchronizers = 1, sdl released, rx_data = 8'h00, rx_valid = 0, tx_req = 0, addr_hit = 0, busy = 0.
REQ-033 rst mid-transfer releases sdl immediately, asynchronously.
REQ-034 After rst, the next transfer starts only at a fresh START.

Structure
REQ-035 State encodings and the R/W polarity constant belong in shared package i2c_pkg, so i2c_master uses the same values.
REQ-036 The synchronizer plus START/STOP/edge detector is sub-module i2c_bus_sync; the FSM, shifter and open-drain driver stay in i2c_slave.

Verification
REQ-037 Write: START, address 0x50 with R/W = 1, ACK, data 0xA5 → sdl low on both 9th clocks; rx_data = 0xA5; one rx_valid pulse.
REQ-038 Address mismatch: START, address 0x51 → sdl never driven, rx_valid never pulses, addr_hit = 0.
REQ-039 Read: START, 0x50 with R/W = 0, tx_data = 0x3C → bus bits 0,0,1,1,1,1,0,0; master NACK → WAIT; STOP → IDLE, busy = 0.
REQ-040 Multi-byte read: tx_data = 0x12 then 0x34, master ACKs the first → two tx_req pulses, bytes 0x12 and 0x34 on the bus.
REQ-041 Repeated START after the write data ACK, then a read of 0x50 → state goes to ADDR, then TX.
REQ-042 rst asserted during bit 4 of RX → sdl released within the same cycle, all outputs at reset values, no rx_valid pulse.
